// File: rtl/booth_divider.sv
// Sequential signed restoring divider: 15-bit dividend / 8-bit divisor.
// Ports: clk, rst (async active-low), St start, Dividend[14:0], Divisor[7:0],
//        Quotient[7:0], Remainder[7:0], Done (result valid), V (overflow/div0).
module booth_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        St,
    input  logic [14:0] Dividend,
    input  logic [7:0]  Divisor,
    output logic [7:0]  Quotient,
    output logic [7:0]  Remainder,
    output logic        Done,
    output logic        V
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DIV,
        FIX
    } state_t;

    state_t      state;
    logic [14:0] dvd;
    logic [7:0]  dvs;
    logic [14:0] qd;
    logic [7:0]  d;
    logic [8:0]  pr;
    logic [3:0]  cnt;
    logic        sq;
    logic        sr;
    logic        z;

    logic [9:0]  pr_sh;
    logic [8:0]  pr_nxt;
    logic        ge;
    logic        ovf;

    // One restoring step: shift {PR,QD} left, trial-subtract D.
    always_comb begin
        pr_sh  = {pr, qd[14]};
        ge     = pr_sh >= {2'b00, d};
        pr_nxt = ge ? 9'(pr_sh - {2'b00, d}) : pr_sh[8:0];
        ovf    = z
               | (!sq && (qd > 15'd127))
               | (sq && (qd > 15'd128));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            dvd       <= '0;
            dvs       <= '0;
            qd        <= '0;
            d         <= '0;
            pr        <= '0;
            cnt       <= '0;
            sq        <= 1'b0;
            sr        <= 1'b0;
            z         <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            Done      <= 1'b0;
            V         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (St) begin
                        dvd   <= Dividend;
                        dvs   <= Divisor;
                        Done  <= 1'b0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    // Magnitudes fit unsigned: 16384 in 15 bits, 128 in 8.
                    qd    <= dvd[14] ? (~dvd + 15'd1) : dvd;
                    d     <= dvs[7] ? (~dvs + 8'd1) : dvs;
                    pr    <= '0;
                    cnt   <= '0;
                    sq    <= dvd[14] ^ dvs[7];
                    sr    <= dvd[14];
                    z     <= (dvs == 8'd0);
                    state <= DIV;
                end
                DIV: begin
                    pr  <= pr_nxt;
                    qd  <= {qd[13:0], ge};
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd14) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    V    <= ovf;
                    Done <= 1'b1;
                    if (ovf) begin
                        Quotient  <= '0;
                        Remainder <= '0;
                    end else begin
                        Quotient  <= sq ? (~qd[7:0] + 8'd1) : qd[7:0];
                        Remainder <= sr ? (~pr[7:0] + 8'd1) : pr[7:0];
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_divider.sv
// Self-checking bench for booth_divider.
// Compares against integer-arithmetic reference division.
module tb_booth_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        St = 1'b0;
    logic [14:0] Dividend = '0;
    logic [7:0]  Divisor = '0;
    logic [7:0]  Quotient;
    logic [7:0]  Remainder;
    logic        Done;
    logic        V;

    int errors = 0;
    int checks = 0;

    booth_divider dut (
        .clk      (clk),
        .rst      (rst),
        .St       (St),
        .Dividend (Dividend),
        .Divisor  (Divisor),
        .Quotient (Quotient),
        .Remainder(Remainder),
        .Done     (Done),
        .V        (V)
    );

    always #5 clk = ~clk;

    // Reference: {V, Quotient, Remainder} from plain signed arithmetic.
    function automatic logic [16:0] model(input logic [14:0] a,
                                          input logic [7:0] b);
        int sa;
        int sb;
        int q;
        int r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) return {1'b1, 16'h0000};
        q = sa / sb;
        r = sa % sb;
        if (q > 127 || q < -128) return {1'b1, 16'h0000};
        return {1'b0, q[7:0], r[7:0]};
    endfunction

    // Pulse St, scramble operands after capture, wait the 17-cycle latency.
    task automatic do_op(input logic [14:0] a, input logic [7:0] b,
                         output logic early, output logic fell);
        @(negedge clk);
        Dividend = a;
        Divisor  = b;
        St       = 1'b1;
        @(posedge clk);
        #1;
        St       = 1'b0;
        fell     = (Done === 1'b0);
        early    = 1'b0;
        Dividend = 15'($urandom);
        Divisor  = 8'($urandom);
        repeat (15) begin
            @(posedge clk);
            #1;
            if (Done !== 1'b0) early = 1'b1;
        end
        @(posedge clk);
        #1;
        if (Done !== 1'b0) early = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({Quotient, Remainder, Done, V} !== 18'h0) begin
            errors++;
            $display("FAIL reset_hold: got Q=%h R=%h Done=%b V=%b, want 0",
                     Quotient, Remainder, Done, V);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({Quotient, Remainder, Done, V} !== 18'h0) begin
            errors++;
            $display("FAIL reset_idle: got Q=%h R=%h Done=%b V=%b, want 0",
                     Quotient, Remainder, Done, V);
        end
    endtask

    task automatic test_basic();
        logic [14:0] ta [2];
        logic [7:0]  tb [2];
        logic [16:0] te [2];
        logic        early;
        logic        fell;
        ta = '{15'h5C24, 15'h1452};
        tb = '{8'h66, 8'h33};
        te = '{{1'b0, 8'hA6, 8'h00}, {1'b0, 8'h66, 8'h00}};
        for (int i = 0; i < 2; i++) begin
            do_op(ta[i], tb[i], early, fell);
            checks++;
            if ({V, Quotient, Remainder} !== te[i] || Done !== 1'b1
                || early || !fell) begin
                errors++;
                $display("FAIL basic%0d: got V=%b Q=%h R=%h Done=%b early=%b fell=%b, want V=%b Q=%h R=%h",
                         i, V, Quotient, Remainder, Done, early, fell,
                         te[i][16], te[i][15:8], te[i][7:0]);
            end
        end
    endtask

    task automatic test_signs();
        logic [14:0] ta [3];
        logic [7:0]  tb [3];
        logic [16:0] te [3];
        logic        early;
        logic        fell;
        ta = '{15'h0064, 15'h7F9C, 15'h7F9C};
        tb = '{8'hF9, 8'h07, 8'hF9};
        te = '{{1'b0, 8'hF2, 8'h02}, {1'b0, 8'hF2, 8'hFE},
               {1'b0, 8'h0E, 8'hFE}};
        for (int i = 0; i < 3; i++) begin
            do_op(ta[i], tb[i], early, fell);
            checks++;
            if ({V, Quotient, Remainder} !== te[i] || Done !== 1'b1
                || early || !fell) begin
                errors++;
                $display("FAIL sign%0d: got V=%b Q=%h R=%h Done=%b early=%b, want V=%b Q=%h R=%h",
                         i, V, Quotient, Remainder, Done, early,
                         te[i][16], te[i][15:8], te[i][7:0]);
            end
        end
    endtask

    task automatic test_range();
        logic [14:0] ta [7];
        logic [7:0]  tb [7];
        logic [16:0] exp;
        logic        early;
        logic        fell;
        ta = '{15'h4080, 15'h4000, 15'h3FFF, 15'h3F01,
               15'h3F80, 15'h1234, 15'h0000};
        tb = '{8'h7F, 8'h80, 8'h01, 8'h7F, 8'h7F, 8'h00, 8'h00};
        for (int i = 0; i < 7; i++) begin
            exp = model(ta[i], tb[i]);
            do_op(ta[i], tb[i], early, fell);
            checks++;
            if ({V, Quotient, Remainder} !== exp || Done !== 1'b1
                || early || !fell) begin
                errors++;
                $display("FAIL range%0d: got V=%b Q=%h R=%h Done=%b early=%b, want V=%b Q=%h R=%h",
                         i, V, Quotient, Remainder, Done, early,
                         exp[16], exp[15:8], exp[7:0]);
            end
        end
    endtask

    task automatic test_ignore();
        @(negedge clk);
        Dividend = 15'h5C24;
        Divisor  = 8'h66;
        St       = 1'b1;
        @(posedge clk);
        #1;
        Dividend = 15'h1452;
        Divisor  = 8'h33;
        repeat (15) @(posedge clk);
        #1;
        St = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({V, Quotient, Remainder} !== {1'b0, 8'hA6, 8'h00}
            || Done !== 1'b1) begin
            errors++;
            $display("FAIL ignore: got V=%b Q=%h R=%h Done=%b, want V=0 Q=a6 R=00 Done=1",
                     V, Quotient, Remainder, Done);
        end
    endtask

    task automatic test_reset_mid();
        logic early;
        logic fell;
        do_op(15'h0064, 8'hF9, early, fell);
        @(negedge clk);
        Dividend = 15'h1452;
        Divisor  = 8'h33;
        St       = 1'b1;
        @(posedge clk);
        #1;
        St = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({Quotient, Remainder, Done, V} !== 18'h0) begin
            errors++;
            $display("FAIL reset_mid: got Q=%h R=%h Done=%b V=%b, want 0",
                     Quotient, Remainder, Done, V);
        end
        @(negedge clk);
        rst = 1'b1;
        do_op(15'h1452, 8'h33, early, fell);
        checks++;
        if ({V, Quotient, Remainder} !== {1'b0, 8'h66, 8'h00}
            || Done !== 1'b1 || early) begin
            errors++;
            $display("FAIL after_reset: got V=%b Q=%h R=%h Done=%b, want V=0 Q=66 R=00",
                     V, Quotient, Remainder, Done);
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] e1;
        logic [16:0] e2;
        e1 = model(15'h7F9C, 8'h07);
        e2 = model(15'h0064, 8'hF9);
        @(negedge clk);
        Dividend = 15'h7F9C;
        Divisor  = 8'h07;
        St       = 1'b1;
        @(posedge clk);
        #1;
        Dividend = 15'h0064;
        Divisor  = 8'hF9;
        repeat (17) @(posedge clk);
        #1;
        checks++;
        if ({V, Quotient, Remainder} !== e1 || Done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: got V=%b Q=%h R=%h Done=%b, want V=%b Q=%h R=%h",
                     V, Quotient, Remainder, Done,
                     e1[16], e1[15:8], e1[7:0]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (Done !== 1'b0 || {V, Quotient, Remainder} !== e1) begin
            errors++;
            $display("FAIL b2b_pulse: got Done=%b Q=%h, want Done=0 Q=%h",
                     Done, Quotient, e1[15:8]);
        end
        repeat (17) @(posedge clk);
        #1;
        St = 1'b0;
        checks++;
        if ({V, Quotient, Remainder} !== e2 || Done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: got V=%b Q=%h R=%h Done=%b, want V=%b Q=%h R=%h",
                     V, Quotient, Remainder, Done,
                     e2[16], e2[15:8], e2[7:0]);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_random();
        logic signed [14:0] a;
        logic [7:0]         b;
        logic [16:0]        exp;
        logic               early;
        logic               fell;
        int                 sa;
        int                 sb;
        int                 sq;
        int                 sr;
        for (int i = 0; i < 1000; i++) begin
            a = 15'($urandom);
            b = 8'($urandom);
            if (i % 2 == 1) a = a >>> $urandom_range(0, 8);
            exp = model(a, b);
            do_op(a, b, early, fell);
            sa = int'(a);
            sb = int'($signed(b));
            sq = int'($signed(Quotient));
            sr = int'($signed(Remainder));
            checks++;
            if ({V, Quotient, Remainder} !== exp || Done !== 1'b1
                || early || !fell
                || (V === 1'b0 && (sq * sb + sr != sa
                    || (sr < 0 ? -sr : sr) >= (sb < 0 ? -sb : sb)))) begin
                errors++;
                $display("FAIL rand%0d %0d/%0d: got V=%b Q=%h R=%h Done=%b, want V=%b Q=%h R=%h",
                         i, sa, sb, V, Quotient, Remainder, Done,
                         exp[16], exp[15:8], exp[7:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_range();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
